// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Results are retired BITS_PER_CYCLE bits per clock behind a start/busy/done handshake.
module muldiv_seq_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int W     = WIDTH;
    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic en);
        return (v ^ {W{en}}) + {{(W-1){1'b0}}, en};
    endfunction

    function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] v, input logic en);
        return (v ^ {(2*W){en}}) + {{(2*W-1){1'b0}}, en};
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [W-1:0]      opb_q, opb_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;

    logic              signed_op_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [W-1:0]      a_mag_s;
    logic [W-1:0]      b_mag_s;
    logic [W+B-1:0]    mul_pp_s;
    logic [W+B-1:0]    mul_sum_s;
    logic [2*W-1:0]    mul_next_s;
    logic [W:0]        div_trial_s;
    logic [W-1:0]      div_rem_s;
    logic [W-1:0]      div_quo_s;
    logic [2*W-1:0]    div_next_s;
    logic [2*W-1:0]    prod_fix_s;
    logic [W-1:0]      quo_fix_s;
    logic [W-1:0]      rem_fix_s;

    // Operand magnitudes and sign flags for the op presented on the inputs.
    always_comb begin
        signed_op_s = (op == OP_MULT) || (op == OP_DIV);
        a_neg_s     = signed_op_s & rs_content[W-1];
        b_neg_s     = signed_op_s & rt_content[W-1];
        a_mag_s     = cond_neg_w(rs_content, a_neg_s);
        b_mag_s     = cond_neg_w(rt_content, b_neg_s);
    end

    // Multiply step: acc holds {partial product, unconsumed multiplier bits}.
    always_comb begin
        mul_pp_s   = {{B{1'b0}}, opb_q} * {{W{1'b0}}, acc_q[B-1:0]};
        mul_sum_s  = {{B{1'b0}}, acc_q[2*W-1:W]} + mul_pp_s;
        mul_next_s = {mul_sum_s, acc_q[W-1:B]};
    end

    // Restoring divide step: acc holds {remainder, dividend/quotient shift register}.
    always_comb begin
        div_rem_s   = acc_q[2*W-1:W];
        div_quo_s   = acc_q[W-1:0];
        div_trial_s = {(W+1){1'b0}};
        for (int i = 0; i < B; i++) begin
            div_trial_s = {div_rem_s, div_quo_s[W-1]};
            div_quo_s   = {div_quo_s[W-2:0], 1'b0};
            if (div_trial_s >= {1'b0, opb_q}) begin
                div_trial_s  = div_trial_s - {1'b0, opb_q};
                div_quo_s[0] = 1'b1;
            end else begin
                div_quo_s[0] = 1'b0;
            end
            div_rem_s = div_trial_s[W-1:0];
        end
        div_next_s = {div_rem_s, div_quo_s};
    end

    // Sign correction; a zero divisor leaves the dividend magnitude in the
    // remainder, so the corrected remainder is exactly the original rs_content.
    always_comb begin
        prod_fix_s = cond_neg_2w(acc_q, neg_res_q);
        quo_fix_s  = cond_neg_w(acc_q[W-1:0], neg_res_q);
        rem_fix_s  = cond_neg_w(acc_q[2*W-1:W], neg_rem_q);
    end

    // Next-state and datapath-update logic of the sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = S_CALC;
                            busy_d    = 1'b1;
                            cnt_d     = {CNT_W{1'b0}};
                            is_div_d  = op[1];
                            neg_res_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            div0_d    = op[1] & (rt_content == {W{1'b0}});
                            if (op[1]) begin
                                opb_d = b_mag_s;
                                acc_d = {{W{1'b0}}, a_mag_s};
                            end else begin
                                opb_d = a_mag_s;
                                acc_d = {{W{1'b0}}, b_mag_s};
                            end
                        end
                        OP_MTHI: begin
                            hi_d = rs_content;
                        end
                        OP_MTLO: begin
                            lo_d = rs_content;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = is_div_q ? div_next_s : mul_next_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_fix_s;
                        lo_d = div0_q ? {W{1'b1}} : quo_fix_s;
                    end else begin
                        hi_d = prod_fix_s[2*W-1:W];
                        lo_d = prod_fix_s[W-1:0];
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any work in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*W){1'b0}};
            opb_q     <= {W{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: a 32/1 instance for directed checks and
// a 32/4 instance for the fast-latency case and a long random sweep.
module tb_muldiv_seq_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start4 = 1'b0;
    logic [2:0]  op4 = 3'd0;
    logic [31:0] rs4 = 32'd0;
    logic [31:0] rt4 = 32'd0;
    logic        flush4 = 1'b0;
    logic        busy4, done4;
    logic [31:0] hi4, lo4;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int e0_edge  = 0;
    int e0_edge4 = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp4_q[$];

    muldiv_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op_i),
        .rs_content(rs), .rt_content(rt), .flush(flush),
        .busy(busy), .done(done), .HI(hi), .LO(lo)
    );

    muldiv_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .op(op4),
        .rs_content(rs4), .rt_content(rt4), .flush(flush4),
        .busy(busy4), .done(done4), .HI(hi4), .LO(lo4)
    );

    always #5 clk = ~clk;

    // Reference: {HI, LO} for ops 0-3 computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        res = 64'd0;
        case (o)
            3'd0: begin q = sa * sb; res = q; end
            3'd1: res = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        start = 1'b1; op_i = o; rs = a; rt = b;
        tick();
        e0_edge = edge_cnt;
        start = 1'b0;
        rs = $urandom; rt = $urandom;
        if (push) exp_q.push_back(model(o, a, b));
    endtask

    task automatic wait_done(input string name, output int lat, output int bcnt);
        int k;
        logic [63:0] e;
        k = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
            if (busy === 1'b1) bcnt++;
        end
        lat = edge_cnt - e0_edge;
        n_tests++;
        if (done !== 1'b1) begin
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, k);
            n_fail++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: done seen with no expected entry, HI=%h LO=%h", name, hi, lo);
            n_fail++;
        end else begin
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
                $display("FAIL %s result: HI=%h LO=%h, required HI=%h LO=%h", name, hi, lo, e[63:32], e[31:0]);
                n_fail++;
            end
        end
    endtask

    task automatic issue4(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start4 = 1'b1; op4 = o; rs4 = a; rt4 = b;
        tick();
        e0_edge4 = edge_cnt;
        start4 = 1'b0;
        rs4 = $urandom; rt4 = $urandom;
        exp4_q.push_back(model(o, a, b));
    endtask

    task automatic wait_done4(input string name, output int lat);
        int k;
        logic [63:0] e;
        k = 0;
        while (done4 !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        lat = edge_cnt - e0_edge4;
        n_tests++;
        if (done4 !== 1'b1 || exp4_q.size() == 0) begin
            $display("FAIL %s: done4=%b after %0d cycles, queued=%0d, required done4=1", name, done4, k, exp4_q.size());
            n_fail++;
            if (exp4_q.size() > 0) void'(exp4_q.pop_front());
        end else begin
            e = exp4_q.pop_front();
            if ({hi4, lo4} !== e) begin
                $display("FAIL %s result: HI=%h LO=%h, required HI=%h LO=%h", name, hi4, lo4, e[63:32], e[31:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_tests++;
        if ({busy, done, hi, lo, busy4, done4, hi4, lo4} !== 132'd0) begin
            $display("FAIL reset_state: busy=%b done=%b HI=%h LO=%h busy4=%b done4=%b, required all zero",
                     busy, done, hi, lo, busy4, done4);
            n_fail++;
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int lat, bcnt;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max", lat, bcnt);
        n_tests++;
        if (lat !== 33) begin
            $display("FAIL multu_latency: %0d edges, required 33", lat); n_fail++;
        end
        n_tests++;
        if (bcnt !== 33) begin
            $display("FAIL multu_busy_cycles: %0d, required 33", bcnt); n_fail++;
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        wait_done("mult_neg", lat, bcnt);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done); n_fail++;
        end
        wait_done("div_neg7_2", lat, bcnt);
        n_tests++;
        if (lat !== 33) begin
            $display("FAIL b2b_div_latency: %0d edges, required 33", lat); n_fail++;
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_overflow", lat, bcnt);
        issue(3'd3, 32'h0000_0007, 32'h0000_0000, 1'b1);
        wait_done("divu_by_zero", lat, bcnt);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
        wait_done("div_neg_by_zero", lat, bcnt);
    endtask

    task automatic test_mthi_ignore();
        int lat, bcnt;
        tick();
        start = 1'b1; op_i = 3'd4; rs = 32'h1234_5678;
        tick();
        start = 1'b0;
        n_tests++;
        if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL mthi: HI=%h busy=%b done=%b, required HI=12345678 busy=0 done=0", hi, busy, done);
            n_fail++;
        end
        issue(3'd3, 32'd100, 32'd7, 1'b1);
        repeat (4) tick();
        start = 1'b1; op_i = 3'd1; rs = 32'h0000_0009; rt = 32'h0000_0009;
        tick();
        start = 1'b0; op_i = 3'd5;
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL start_while_busy: busy=%b, required 1", busy); n_fail++;
        end
        wait_done("divu_100_7", lat, bcnt);
        n_tests++;
        if (lat !== 33) begin
            $display("FAIL ignored_start_latency: %0d edges, required 33", lat); n_fail++;
        end
    endtask

    task automatic test_flush_reset();
        int lat, bcnt;
        bit seen;
        start = 1'b1; op_i = 3'd4; rs = 32'hAAAA_0000; tick();
        op_i = 3'd5; rs = 32'h0000_5555; tick();
        start = 1'b0;
        issue(3'd1, 32'h0000_0003, 32'h0000_0004, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
            $display("FAIL flush: busy=%b done=%b HI=%h LO=%h, required 0 0 aaaa0000 00005555", busy, done, hi, lo);
            n_fail++;
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || hi !== 32'hAAAA_0000) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            $display("FAIL flush_no_done: late done or HI change seen, HI=%h, required none", hi); n_fail++;
        end
        flush = 1'b1;
        issue(3'd3, 32'd100, 32'd7, 1'b1);
        flush = 1'b0;
        wait_done("flush_start_idle", lat, bcnt);
        issue(3'd1, 32'h0000_0003, 32'h0000_0004, 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL async_reset: HI=%h LO=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
            n_fail++;
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_bpc4();
        int lat;
        issue4(3'd1, 32'h0001_0000, 32'h0001_0000);
        wait_done4("bpc4_multu", lat);
        n_tests++;
        if (lat !== 9) begin
            $display("FAIL bpc4_latency: %0d edges, required 9", lat); n_fail++;
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [2:0] o;
        for (int i = 0; i < 1000; i++) begin
            o = 3'($urandom_range(0, 3));
            issue4(o, pick(), pick());
            wait_done4("rand_bpc4", lat);
        end
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            issue(o, pick(), pick(), 1'b1);
            wait_done("rand_bpc1", lat, bcnt);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_mthi_ignore();
        test_flush_reset();
        test_bpc4();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Parametrised, multi-cycle successor to the combinational MULT/MULTU/DIV/DIVU/MTHI/MTLO path of the datapath ALU.
- Owns the architectural HI/LO registers.
- Computes multiply/divide iteratively, BITS_PER_CYCLE result bits per clock, behind a start/busy/done handshake.
- Sits beside the ALU in execute; the control FSM stalls MFHI/MFLO and new mult/div ops while busy=1.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1: bits retired per iteration. Legal values are 1, 2 and 4, and the value must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are reserved and ignored.
- rs_content  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO data).
- rt_content  in  WIDTH  operand B (divisor / multiplier).
- flush  in  1  synchronous cancel of the in-flight operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO are valid at the same time.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: the block has one clock. Reset is asynchronous and active-low.
  - While reset_n=0, HI=0, LO=0, busy=0, done=0, and the FSM is in IDLE.
  - Reset mid-operation discards all work immediately.
- States: IDLE, CALC, FIX, DONE. Let N = WIDTH/BITS_PER_CYCLE.
- IDLE, start=1 at edge E0 with op 0-3:
  - Latch operands: magnitudes for signed ops, plus the result-sign flags.
  - Clear the iteration counter and go to CALC. busy=1 from E0.
- IDLE, start=1 with op 4/5:
  - HI (or LO) <= rs_content at E0. State stays IDLE, busy stays 0, no done.
- IDLE, start=1 with op 6/7: no effect.
- CALC: one iteration per edge, edges E1..EN.
  - MULT*: shift-add of BITS_PER_CYCLE multiplier bits per edge into a 2*WIDTH accumulator.
  - DIV*: restoring divide producing BITS_PER_CYCLE quotient bits per edge.
  - Counter reaches N-1 -> FIX.
- FIX (edge EN+1):
  - Apply sign correction:
    - MULT: negate the 2*WIDTH product if the operand signs differ.
    - DIV: the quotient is negative if the signs differ. The remainder takes the sign of the dividend. Truncation is toward zero.
  - Write HI/LO: multiply gives HI=product[2W-1:W], LO=product[W-1:0]; divide gives HI=remainder, LO=quotient.
  - Set done=1 and busy=0 at the same edge -> DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE.
  - A start in the DONE cycle is accepted, exactly as in IDLE (back-to-back operation).
- Latency: done is high in the cycle after edge E0+N+1; that is 33 edges for the 32/1 configuration and 9 edges for the 32/4 configuration.
- Divide by zero (rt_content=0, DIV or DIVU): the iteration still runs the full N cycles. FIX forces LO={WIDTH{1}} and HI=rs_content.
- Signed overflow (DIV of most-negative by -1): LO=most-negative, HI=0. This is not an error.
- start while busy (CALC/FIX), including op 4/5: ignored, with no queueing. The operands of the in-flight operation are unaffected.
- flush=1 in CALC or FIX:
  - Next edge: IDLE, busy=0, no done. HI/LO keep their pre-operation values.
  - If flush and start arrive together in IDLE, flush has no effect and start is honoured.
- Input changes on rs_content/rt_content after E0 do not affect the result, because the operands are latched.
- HI/LO change only at FIX, on MTHI/MTLO, or on reset.

Test Plan:
- MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF (WIDTH=32, BITS_PER_CYCLE=1) -> done pulse 33 edges after accept; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT -3*5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Issue a back-to-back DIV in the done cycle and check it is accepted.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
- MTHI rs=0x12345678 while idle -> HI=0x12345678 after one edge, busy stays 0, no done. Then start DIVU 100/7, pulse start with MULTU at iteration 5 (ignored), and check HI=2, LO=14.
- Preload HI=0xAAAA0000 and LO=0x5555. Start MULTU, assert flush at iteration 10 -> busy=0 next cycle, no done, HI/LO unchanged. Then pull reset_n low mid-CALC -> HI=LO=0, busy=0 without waiting for a clock edge.
- BITS_PER_CYCLE=4 build: MULTU 0x0001_0000*0x0001_0000 -> done 9 edges after accept, HI=0x00000001, LO=0. Random signed/unsigned mult/div sweep of 1000 operations against a reference model.
